branch_predict_unit: RTL
========================

// Module: branch_predict_unit
// PURPOSE
//  Next-generation branch resolution for the npc pipeline. Resolves Branch/Zero/Less in EX with
//  the existing 3-bit Branch encoding, and adds a BHT_DEPTH-entry table of 2-bit saturating
//  counters for direction prediction.
//  Prediction is read in ID, where decode forms the taken target. A registered redirect with
//  the correct PC goes to IF on misprediction or on any jump.
// PARAMETERS
//  XLEN       32  datapath / PC width
//  BHT_DEPTH  64  counter entries; power of 2, >=2; IDX_W = $clog2(BHT_DEPTH)
//  CNT_RST    1   reset value of every counter (0..3); 1 = weakly not-taken
// PORTS
//  clk            in   1     clock, rising edge
//  rst            in   1     asynchronous reset, active-high
//  id_pc          in   XLEN  PC of instruction in ID (lookup)
//  id_pred_taken  out  1     predicted direction for id_pc; combinational from table
//  ex_valid       in   1     EX holds a real instruction
//  ex_branch      in   3     000 none, 001 jal, 010 jalr, 100 beq, 101 bne, 110 blt(u), 111 bge(u)
//  ex_zero        in   1     ALU zero flag
//  ex_less        in   1     ALU less flag
//  ex_pred_taken  in   1     prediction carried down the pipe with this instruction
//  ex_pc          in   XLEN  PC of EX instruction
//  ex_imm         in   XLEN  sign-extended immediate
//  ex_rs1         in   XLEN  rs1 value (jalr base)
//  redirect_valid out  1     registered: flush younger stages, fetch redirect_pc
//  redirect_pc    out  XLEN  registered correct next PC
// BEHAVIOUR
//  - Index: idx(pc) = pc[IDX_W+1:2]. Lookup: id_pred_taken = bht[idx(id_pc)][1].
//  - Actual taken (EX, combinational):
//    jal/jalr = 1; beq = zero; bne = ~zero; blt = less; bge = ~less; none and 011 = 0.
//  - Target: jalr -> (rs1+imm) & ~1; other taken -> pc+imm; not taken -> pc+4.
//    All sums are mod 2^XLEN.
//  - Mispredict: conditional (1xx) with taken != ex_pred_taken; jal/jalr always redirect.
//  - Resolve qualifier: res = ex_valid & ~redirect_valid.
//    An EX instruction in a redirect cycle is wrong-path: no redirect, no table update.
//  - Latency: a mispredict resolving in cycle N gives redirect_valid=1 in cycle N+1 only,
//    with redirect_pc = that target. Otherwise redirect_valid = 0 and redirect_pc holds.
//  - Back-to-back: redirect_valid is never high two consecutive cycles (second EX is masked).
//  - Counter FSM, one per entry:
//    SNT 00 <-> WNT 01 <-> WT 10 <-> ST 11.
//    Taken increments, not-taken decrements, saturating at 11/00.
//    Only res & conditional branches update bht[idx(ex_pc)], at the clock edge after resolve.
//    jal/jalr never update.
//  - Same-cycle lookup and update of one index: lookup returns the pre-update value
//    (no bypass); the new value is visible next cycle.
//  - Reset (async, any cycle, including mid-redirect):
//    all counters = CNT_RST; redirect_valid = 0; redirect_pc = 0.
//    After release, first resolve behaves as from cold; a pending redirect is dropped.
// CONFIGURATION
//  BRU_PERF_EN defined:
//    adds outputs perf_br_cnt[31:0] and perf_mis_cnt[31:0], reset 0, wrapping.
//    perf_br_cnt +1 per res with ex_branch 1xx; perf_mis_cnt +1 per redirect caused by a 1xx.
//  BRU_PERF_EN undefined: those ports and registers do not exist; behaviour is otherwise identical.
// TESTING
//  1 Reset, then id_pc=0x80000000 -> id_pred_taken=0; redirect_valid=0; redirect_pc=0.
//  2 beq at pc 0x80000010, imm=0x20, zero=1, pred=0 -> next cycle redirect_valid=1,
//    redirect_pc=0x80000030, bht[4]=10; id_pc=0x80000010 then predicts 1.
//  3 Same beq taken twice more -> counter saturates at 11; one not-taken, pred=1 ->
//    redirect_pc=0x80000014, counter 10, prediction still 1.
//  4 jalr rs1=0x80001003, imm=4 -> redirect_pc=0x80001006; bht unchanged.
//  5 Mispredict in cycle N, another mispredicting ex_valid in cycle N+1 -> redirect only
//    in N+1, not N+2; no second update.
//  6 rst pulse while redirect_valid=1 -> immediately 0; all counters CNT_RST.
//    With BRU_PERF_EN: counts 0 after reset; after test 2, br=1 and mis=1.

Source files
------------

// File: rtl/branch_predict_unit.sv
// EX-stage branch resolution with a table of 2-bit saturating direction counters read in ID.
// Registered redirect one cycle after resolve; optional perf counters under BRU_PERF_EN.
module branch_predict_unit #(
    parameter int XLEN      = 32,
    parameter int BHT_DEPTH = 64,
    parameter int CNT_RST   = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] id_pc,
    output logic            id_pred_taken,
    input  logic            ex_valid,
    input  logic [2:0]      ex_branch,
    input  logic            ex_zero,
    input  logic            ex_less,
    input  logic            ex_pred_taken,
    input  logic [XLEN-1:0] ex_pc,
    input  logic [XLEN-1:0] ex_imm,
    input  logic [XLEN-1:0] ex_rs1,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc
`ifdef BRU_PERF_EN
    ,
    output logic [31:0]     perf_br_cnt,
    output logic [31:0]     perf_mis_cnt
`endif
);
    localparam int IDX_W = $clog2(BHT_DEPTH);

    typedef enum logic [1:0] {SNT = 2'b00, WNT = 2'b01, WT = 2'b10, ST = 2'b11} cnt_e;

    localparam logic [1:0] CNT_RST_V = CNT_RST[1:0];

    cnt_e            r_bht [BHT_DEPTH];
    logic            r_redirect_valid;
    logic [XLEN-1:0] r_redirect_pc;

    logic [IDX_W-1:0] w_id_idx;
    logic [IDX_W-1:0] w_ex_idx;
    logic             w_res;
    logic             w_cond;
    logic             w_jump;
    logic             w_taken;
    logic             w_mis;
    logic [XLEN-1:0]  w_target;
    cnt_e             w_cnt_cur;
    cnt_e             w_cnt_nxt;
    logic             w_unused_bits;

    assign w_id_idx      = id_pc[IDX_W+1:2];
    assign w_ex_idx      = ex_pc[IDX_W+1:2];
    assign w_unused_bits = ^{id_pc[XLEN-1:IDX_W+2], id_pc[1:0], ex_pc[XLEN-1:IDX_W+2], ex_pc[1:0]};

    // No bypass: a same-cycle update to this index shows up next cycle.
    assign id_pred_taken = r_bht[w_id_idx][1];

    // Instructions sitting in EX during a redirect cycle are wrong-path.
    assign w_res  = ex_valid & ~r_redirect_valid;
    assign w_cond = ex_branch[2];
    assign w_jump = (ex_branch == 3'b001) || (ex_branch == 3'b010);

    always_comb begin
        w_taken = 1'b0;
        case (ex_branch)
            3'b001, 3'b010: w_taken = 1'b1;
            3'b100:         w_taken = ex_zero;
            3'b101:         w_taken = ~ex_zero;
            3'b110:         w_taken = ex_less;
            3'b111:         w_taken = ~ex_less;
            default:        w_taken = 1'b0;
        endcase
    end

    always_comb begin
        w_target = ex_pc + XLEN'(4);
        if (ex_branch == 3'b010)
            w_target = (ex_rs1 + ex_imm) & ~XLEN'(1);
        else if (w_taken)
            w_target = ex_pc + ex_imm;
    end

    assign w_mis = w_res & (w_jump | (w_cond & (w_taken != ex_pred_taken)));

    always_comb begin
        w_cnt_cur = r_bht[w_ex_idx];
        w_cnt_nxt = w_cnt_cur;
        case (w_cnt_cur)
            SNT: w_cnt_nxt = w_taken ? WNT : SNT;
            WNT: w_cnt_nxt = w_taken ? WT  : SNT;
            WT:  w_cnt_nxt = w_taken ? ST  : WNT;
            ST:  w_cnt_nxt = w_taken ? ST  : WT;
            default: w_cnt_nxt = w_cnt_cur;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < BHT_DEPTH; i++)
                r_bht[i] <= cnt_e'(CNT_RST_V);
        end else if (w_res && w_cond) begin
            r_bht[w_ex_idx] <= w_cnt_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_redirect_valid <= 1'b0;
            r_redirect_pc    <= '0;
        end else begin
            r_redirect_valid <= w_mis;
            if (w_mis)
                r_redirect_pc <= w_target;
        end
    end

    assign redirect_valid = r_redirect_valid;
    assign redirect_pc    = r_redirect_pc;

`ifdef BRU_PERF_EN
    logic [31:0] r_perf_br_cnt;
    logic [31:0] r_perf_mis_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_perf_br_cnt  <= '0;
            r_perf_mis_cnt <= '0;
        end else begin
            if (w_res && w_cond)
                r_perf_br_cnt <= r_perf_br_cnt + 32'd1;
            if (w_mis && w_cond)
                r_perf_mis_cnt <= r_perf_mis_cnt + 32'd1;
        end
    end

    assign perf_br_cnt  = r_perf_br_cnt;
    assign perf_mis_cnt = r_perf_mis_cnt;
`endif

endmodule
